// File: rtl/tt_logic_engine.sv
// Programmable N-input truth-table evaluator with a LAT-stage valid/ready pipeline
// and a serially loaded shadow table. Optional macro TT_EVAL_COUNT_EN adds result counters.
module tt_logic_engine #(
    parameter int                      N_IN     = 4,
    parameter int                      LAT      = 2,
    parameter logic [(1<<N_IN)-1:0]    TT_RESET = 16'hECF1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out,
    input  logic            cfg_shift,
    input  logic            cfg_bit,
    input  logic            cfg_commit,
    output logic            cfg_err
`ifdef TT_EVAL_COUNT_EN
    ,
    output logic [15:0]     ones_cnt,
    output logic [15:0]     zeros_cnt
`endif
);

    localparam int TT_W  = 1 << N_IN;
    localparam int CNT_W = $clog2(TT_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TT_W);

    if (N_IN < 1 || N_IN > 6) begin : g_bad_n_in
        $error("tt_logic_engine: N_IN must be in 1..6");
    end
    if (LAT < 1 || LAT > 8) begin : g_bad_lat
        $error("tt_logic_engine: LAT must be in 1..8");
    end

    logic [TT_W-1:0]  active_tt_q, active_tt_d;
    logic [TT_W-1:0]  shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             commit_ok;

    logic [LAT-1:0]   vld_q, vld_d;
    logic [LAT-1:0]   res_q, res_d;
    logic             stall;
    logic             accept;
    logic             lookup;

    assign stall    = vld_q[LAT-1] & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    // Lookup uses the table as registered, so a commit in the same cycle is not yet visible.
    assign lookup   = active_tt_q[in_vec];

    genvar gi;
    for (gi = 0; gi < LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign vld_d[gi] = stall ? vld_q[gi] : accept;
            assign res_d[gi] = stall ? res_q[gi] : (accept & lookup);
        end else begin : g_tail
            assign vld_d[gi] = stall ? vld_q[gi] : vld_q[gi-1];
            assign res_d[gi] = stall ? res_q[gi] : res_q[gi-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            res_q <= '0;
        end else begin
            vld_q <= vld_d;
            res_q <= res_d;
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out       = res_q[LAT-1];

    // Shift is applied first; the commit then judges the post-shift shadow and count.
    always_comb begin
        shadow_d    = shadow_q;
        cnt_d       = cnt_q;
        active_tt_d = active_tt_q;
        err_d       = err_q;
        commit_ok   = 1'b0;
        if (cfg_shift) begin
            shadow_d = {cfg_bit, shadow_q[TT_W-1:1]};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (cfg_commit) begin
            if (cnt_d == CNT_FULL) begin
                active_tt_d = shadow_d;
                commit_ok   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_tt_q <= TT_RESET;
            shadow_q    <= TT_RESET;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            active_tt_q <= active_tt_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign cfg_err = err_q;

`ifdef TT_EVAL_COUNT_EN
    logic [15:0] ones_q, ones_d;
    logic [15:0] zeros_q, zeros_d;
    logic        xfer;

    assign xfer = out_valid & out_ready;

    // A successful commit restarts the statistics for the new function.
    always_comb begin
        ones_d  = ones_q;
        zeros_d = zeros_q;
        if (commit_ok) begin
            ones_d  = '0;
            zeros_d = '0;
        end else if (xfer) begin
            if (out && ones_q != 16'hFFFF) begin
                ones_d = ones_q + 16'd1;
            end
            if (!out && zeros_q != 16'hFFFF) begin
                zeros_d = zeros_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q  <= '0;
            zeros_q <= '0;
        end else begin
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
        end
    end

    assign ones_cnt  = ones_q;
    assign zeros_cnt = zeros_q;
`else
    logic unused_commit_ok;
    assign unused_commit_ok = commit_ok;
`endif

endmodule

// File: tb/tb_tt_logic_engine.sv
// Scoreboard bench for tt_logic_engine: a default instance (N_IN=4, LAT=2, ECF1) and
// a wide instance (N_IN=6, LAT=1, TT=1). Expected results are hand-computed per vector.
module tb_tt_logic_engine;

    typedef struct {
        bit exp;
        int due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_vec;
    logic        out_valid, out_ready, out;
    logic        cfg_shift, cfg_bit, cfg_commit, cfg_err;

    logic        in_valid6, in_ready6;
    logic [5:0]  in_vec6;
    logic        out_valid6, out_ready6, out6;
    logic        cfg_shift6, cfg_bit6, cfg_commit6, cfg_err6;
`ifdef TT_EVAL_COUNT_EN
    logic [15:0] ones_cnt, zeros_cnt, ones_cnt6, zeros_cnt6;
`endif

    exp_t q[$];
    exp_t q6[$];
    exp_t e, e6;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic held;

    tt_logic_engine #(.N_IN(4), .LAT(2), .TT_RESET(16'hECF1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .cfg_shift(cfg_shift), .cfg_bit(cfg_bit), .cfg_commit(cfg_commit), .cfg_err(cfg_err)
`ifdef TT_EVAL_COUNT_EN
        , .ones_cnt(ones_cnt), .zeros_cnt(zeros_cnt)
`endif
    );

    tt_logic_engine #(.N_IN(6), .LAT(1), .TT_RESET(64'h1)) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6), .in_vec(in_vec6),
        .out_valid(out_valid6), .out_ready(out_ready6), .out(out6),
        .cfg_shift(cfg_shift6), .cfg_bit(cfg_bit6), .cfg_commit(cfg_commit6), .cfg_err(cfg_err6)
`ifdef TT_EVAL_COUNT_EN
        , .ones_cnt(ones_cnt6), .zeros_cnt(zeros_cnt6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: each negedge with valid & ready is exactly one transfer at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 32'(out), 32'hDEAD);
            end else begin
                e = q.pop_front();
                $display("dut4 out=%0d exp=%0d cyc=%0d", out, e.exp, cyc);
                chk("result", 32'(out), 32'(e.exp));
                if (e.due >= 0) chk("latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid6 && out_ready6) begin
            if (q6.size() == 0) begin
                chk("unexpected_out6", 32'(out6), 32'hDEAD);
            end else begin
                e6 = q6.pop_front();
                $display("dut6 out=%0d exp=%0d cyc=%0d", out6, e6.exp, cyc);
                chk("result6", 32'(out6), 32'(e6.exp));
                if (e6.due >= 0) chk("latency6", cyc, e6.due);
            end
        end
    end

    // All drive tasks start and end at posedge + 1.
    task automatic send(input logic [3:0] v, input bit exp, input bit lat);
        in_valid = 1'b1;
        in_vec   = v;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{exp, lat ? cyc + 2 : -1});
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send_timeout", 32'(in_ready), 32'h1);
        in_valid = 1'b0;
    endtask

    task automatic send6(input logic [5:0] v, input bit exp);
        in_valid6 = 1'b1;
        in_vec6   = v;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready6) begin
                q6.push_back('{exp, cyc + 1});
                @(posedge clk); #1;
                in_valid6 = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send6_timeout", 32'(in_ready6), 32'h1);
        in_valid6 = 1'b0;
    endtask

    task automatic shift_bits(input logic [15:0] val, input int n);
        logic [15:0] v;
        v = val;
        for (int i = 0; i < n; i++) begin
            cfg_shift = 1'b1;
            cfg_bit   = v[i];
            @(posedge clk); #1;
        end
        cfg_shift = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        @(posedge clk); #1;
        cfg_commit = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && q6.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_q", 32'(q.size()), 32'h0);
        chk("drain_q6", 32'(q6.size()), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        q6.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp2 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        rst_n = 1'b0;
        in_valid = 0; in_vec = '0; out_ready = 1; cfg_shift = 0; cfg_bit = 0; cfg_commit = 0;
        in_valid6 = 0; in_vec6 = '0; out_ready6 = 1; cfg_shift6 = 0; cfg_bit6 = 0; cfg_commit6 = 0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_cfg_err", 32'(cfg_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // Back-to-back vectors against ECF1, latency 2.
        send(4'd0, 1'b1, 1'b1);
        send(4'd1, 1'b0, 1'b1);
        send(4'd4, 1'b1, 1'b1);
        send(4'd8, 1'b0, 1'b1);
        send(4'd10, 1'b1, 1'b1);
        send(4'd15, 1'b1, 1'b1);
        drain();

        // Three-cycle downstream stall with continuous input.
        fork
            begin
                for (int i = 0; i < 8; i++) send(4'(i), exp2[i], 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out;
                chk("stall_in_ready", 32'(in_ready), 32'h0);
                chk("stall_valid", 32'(out_valid), 32'h1);
                repeat (2) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'h0);
                    chk("stall_valid", 32'(out_valid), 32'h1);
                    chk("stall_out_held", 32'(out), 32'(held));
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Load 8000; the 16th shift coincides with the commit and an accepted vector.
        shift_bits(16'h8000, 15);
        cfg_shift = 1'b1; cfg_bit = 1'b1; cfg_commit = 1'b1;
        send(4'd0, 1'b1, 1'b1);
        cfg_shift = 1'b0; cfg_commit = 1'b0;
        send(4'd15, 1'b1, 1'b1);
        send(4'd0, 1'b0, 1'b1);
        send(4'd1, 1'b0, 1'b1);
        send(4'd14, 1'b0, 1'b1);
        drain();
        chk("commit_ok_err", 32'(cfg_err), 32'h0);

        // Short loads fail and clear the count; a full load still commits.
        do_reset();
        shift_bits(16'hFFFF, 7);
        commit();
        chk("short_commit_err", 32'(cfg_err), 32'h1);
        send(4'd3, 1'b0, 1'b1);
        send(4'd0, 1'b1, 1'b1);
        shift_bits(16'h0000, 9);
        commit();
        send(4'd3, 1'b0, 1'b1);
        shift_bits(16'h0001, 16);
        commit();
        send(4'd0, 1'b1, 1'b1);
        send(4'd3, 1'b0, 1'b1);
        send(4'd4, 1'b0, 1'b1);
        send(4'd15, 1'b0, 1'b1);
        drain();
        chk("err_sticky", 32'(cfg_err), 32'h1);

        // Reset with two results in flight.
        send(4'd4, 1'b0, 1'b1);
        send(4'd5, 1'b0, 1'b1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out", 32'(out), 32'h0);
        chk("midrst_cfg_err", 32'(cfg_err), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        send(4'd4, 1'b1, 1'b1);
        send(4'd3, 1'b0, 1'b1);
        send(4'd15, 1'b1, 1'b1);
        drain();

        // Wide instance: only vector 0 maps to 1.
        for (int v = 0; v < 64; v++) send6(6'(v), (v == 0));
        drain();
        chk("dut6_cfg_err", 32'(cfg_err6), 32'h0);
`ifdef TT_EVAL_COUNT_EN
        chk("ones_cnt6", 32'(ones_cnt6), 32'd1);
        chk("zeros_cnt6", 32'(zeros_cnt6), 32'd63);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
